// File: rtl/busy_table_pkg.sv
// busy_table_pkg
//   Shared constants for the busy table: default table depth, the index width
//   derivation and the encoding of a single busy flag.
//   Imported by busy_table and busy_table_dec.
package busy_table_pkg;

  // Default number of tracked physical registers.
  localparam int N_ENTRIES_DEF = 32;

  // Encoding of one busy flag.
  localparam logic BUSY  = 1'b1;
  localparam logic READY = 1'b0;

  // Index width needed to address n entries.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/busy_table_dec.sv
// busy_table_dec
//   Binary index plus valid to one-hot mask decoder.
//   Ports:
//     valid  in   request valid; mask is all zero when low
//     idx    in   binary entry index (IDX_W bits)
//     mask   out  one-hot N_ENTRIES mask, bit i set when valid and idx == i
//   An index at or above N_ENTRIES decodes to an all-zero mask.
module busy_table_dec
  import busy_table_pkg::*;
#(
  parameter int N_ENTRIES = N_ENTRIES_DEF,
  parameter int IDX_W     = idx_width(N_ENTRIES)
) (
  input  logic                 valid,
  input  logic [IDX_W-1:0]     idx,
  output logic [N_ENTRIES-1:0] mask
);

  // Compare against every legal entry number so out-of-range indices
  // naturally produce no hit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid && (idx == IDX_W'(i))) begin
        mask[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/busy_table.sv
// busy_table
//   Scoreboard of busy physical registers. An allocate (set) marks an entry
//   busy, a writeback (clear) marks it ready, flush clears the whole table.
//   Entry 0 is hardwired ready. A running busy_count is kept alongside the
//   flags so the population never has to be recounted.
//   Ports:
//     clk, rst_aL          clock (rising edge), async active-low reset
//     set_valid, set_idx   mark set_idx busy
//     clr_valid, clr_idx   mark clr_idx ready (set wins on the same index)
//     flush                clear every entry, overrides set/clear
//     rd0_idx / rd0_busy   read port 0
//     rd1_idx / rd1_busy   read port 1
//     busy_vec             registered busy flags, bit i = entry i
//     busy_count           registered number of busy entries
//     all_idle             high when no entry is busy
//   Configuration macro:
//     BUSY_TABLE_BYPASS_EN  when defined, a read port whose index matches a
//                           same-cycle clear (no flush, no same-index set)
//                           returns ready immediately.
module busy_table
  import busy_table_pkg::*;
#(
  parameter int N_ENTRIES = N_ENTRIES_DEF,
  parameter int IDX_W     = idx_width(N_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 set_valid,
  input  logic [IDX_W-1:0]     set_idx,
  input  logic                 clr_valid,
  input  logic [IDX_W-1:0]     clr_idx,
  input  logic                 flush,
  input  logic [IDX_W-1:0]     rd0_idx,
  output logic                 rd0_busy,
  input  logic [IDX_W-1:0]     rd1_idx,
  output logic                 rd1_busy,
  output logic [N_ENTRIES-1:0] busy_vec,
  output logic [IDX_W:0]       busy_count,
  output logic                 all_idle
);

  // Read ports index a vector padded to the full index range, so any index
  // beyond the table reads the zero padding.
  localparam int RD_W = 1 << IDX_W;

  // Every entry except entry 0 may change state.
  localparam logic [N_ENTRIES-1:0] LIVE = {{(N_ENTRIES-1){1'b1}}, 1'b0};

  logic [N_ENTRIES-1:0] set_mask;
  logic [N_ENTRIES-1:0] clr_mask;
  logic [N_ENTRIES-1:0] set_eff;
  logic [N_ENTRIES-1:0] clr_eff;
  logic                 set_new;
  logic                 clr_old;
  logic [N_ENTRIES-1:0] busy_nxt;
  logic [IDX_W:0]       count_nxt;
  logic [RD_W-1:0]      busy_pad;

  busy_table_dec #(
    .N_ENTRIES (N_ENTRIES),
    .IDX_W     (IDX_W)
  ) u_set_dec (
    .valid (set_valid),
    .idx   (set_idx),
    .mask  (set_mask)
  );

  busy_table_dec #(
    .N_ENTRIES (N_ENTRIES),
    .IDX_W     (IDX_W)
  ) u_clr_dec (
    .valid (clr_valid),
    .idx   (clr_idx),
    .mask  (clr_mask)
  );

  // A clear that hits the entry being set this cycle is dropped: set wins.
  assign set_eff = set_mask & LIVE;
  assign clr_eff = clr_mask & LIVE & ~set_eff;

  // Count moves only when a flag actually flips, which keeps busy_count equal
  // to the popcount without ever wrapping.
  assign set_new = |(set_eff & ~busy_vec);
  assign clr_old = |(clr_eff & busy_vec);

  // Next-state of the flags and the counter; flush overrides everything.
  always_comb begin
    busy_nxt  = busy_vec;
    count_nxt = busy_count;
    if (flush) begin
      busy_nxt  = '0;
      count_nxt = '0;
    end else begin
      busy_nxt  = (busy_vec & ~clr_eff) | set_eff;
      count_nxt = busy_count + (IDX_W+1)'(set_new) - (IDX_W+1)'(clr_old);
    end
  end

  // State registers; reset discards whatever request is pending.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      busy_vec   <= {N_ENTRIES{READY}};
      busy_count <= '0;
    end else begin
      busy_vec   <= busy_nxt;
      busy_count <= count_nxt;
    end
  end

  assign all_idle = ~|busy_vec;
  assign busy_pad = RD_W'(busy_vec);

`ifdef BUSY_TABLE_BYPASS_EN
  logic clr_bypass;

  // A same-index set keeps the entry busy, so no bypass in that case.
  assign clr_bypass = clr_valid && !flush && !(set_valid && (set_idx == clr_idx));
  assign rd0_busy   = (clr_bypass && (rd0_idx == clr_idx)) ? READY : busy_pad[rd0_idx];
  assign rd1_busy   = (clr_bypass && (rd1_idx == clr_idx)) ? READY : busy_pad[rd1_idx];
`else
  assign rd0_busy = busy_pad[rd0_idx];
  assign rd1_busy = busy_pad[rd1_idx];
`endif

endmodule

// File: tb/tb_busy_table.sv
// tb_busy_table
//   Self-checking bench for busy_table with the default 32 entries. Directed
//   scenarios followed by random traffic, all compared against a behavioural
//   model held as an array of per-entry flags.
module tb_busy_table;

  localparam int N = 32;
  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst_aL = 1'b0;
  logic         set_valid = 1'b0;
  logic [W-1:0] set_idx = '0;
  logic         clr_valid = 1'b0;
  logic [W-1:0] clr_idx = '0;
  logic         flush = 1'b0;
  logic [W-1:0] rd0_idx = '0;
  logic         rd0_busy;
  logic [W-1:0] rd1_idx = '0;
  logic         rd1_busy;
  logic [N-1:0] busy_vec;
  logic [W:0]   busy_count;
  logic         all_idle;

  bit modelBusy [N];
  int nCompared = 0;
  int nMismatched = 0;

  busy_table #(
    .N_ENTRIES (N),
    .IDX_W     (W)
  ) dut (
    .clk        (clk),
    .rst_aL     (rst_aL),
    .set_valid  (set_valid),
    .set_idx    (set_idx),
    .clr_valid  (clr_valid),
    .clr_idx    (clr_idx),
    .flush      (flush),
    .rd0_idx    (rd0_idx),
    .rd0_busy   (rd0_busy),
    .rd1_idx    (rd1_idx),
    .rd1_busy   (rd1_busy),
    .busy_vec   (busy_vec),
    .busy_count (busy_count),
    .all_idle   (all_idle)
  );

  always #5 clk = ~clk;

  function automatic int modelCount();
    int c = 0;
    for (int i = 0; i < N; i++) c += modelBusy[i] ? 1 : 0;
    return c;
  endfunction

  function automatic logic [N-1:0] modelVec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = modelBusy[i];
    return v;
  endfunction

  // Expected read-port value for the inputs currently applied.
  function automatic logic expectRead(input int idx);
    logic e = modelBusy[idx];
`ifdef BUSY_TABLE_BYPASS_EN
    if (clr_valid && !flush && int'(clr_idx) == idx &&
        !(set_valid && int'(set_idx) == idx))
      e = 1'b0;
`endif
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_vec"},   64'(busy_vec),   64'(modelVec()));
    checkOutput({tag, "_count"}, 64'(busy_count), 64'(modelCount()));
    checkOutput({tag, "_idle"},  64'(all_idle),   64'(modelCount() == 0));
  endtask

  // Drive one cycle of requests, check read ports before the edge and the
  // registered state after it.
  task automatic applyStimulus(input string tag, input logic sv, input int si,
                               input logic cv, input int ci, input logic fl,
                               input int r0, input int r1);
    @(negedge clk);
    set_valid = sv;
    set_idx   = W'(si);
    clr_valid = cv;
    clr_idx   = W'(ci);
    flush     = fl;
    rd0_idx   = W'(r0);
    rd1_idx   = W'(r1);
    #1;
    checkOutput({tag, "_rd0"}, 64'(rd0_busy), 64'(expectRead(r0)));
    checkOutput({tag, "_rd1"}, 64'(rd1_busy), 64'(expectRead(r1)));
    @(posedge clk);
    if (fl) begin
      foreach (modelBusy[i]) modelBusy[i] = 1'b0;
    end else begin
      if (cv && ci != 0 && !(sv && si == ci)) modelBusy[ci] = 1'b0;
      if (sv && si != 0) modelBusy[si] = 1'b1;
    end
    #1;
    checkRegs(tag);
  endtask

  task automatic idleInputs();
    @(negedge clk);
    set_valid = 1'b0;
    clr_valid = 1'b0;
    flush     = 1'b0;
  endtask

  initial begin
    foreach (modelBusy[i]) modelBusy[i] = 1'b0;
    rd0_idx = W'(5);
    rd1_idx = W'(9);
    #2;
    checkRegs("reset");
    checkOutput("reset_rd0", 64'(rd0_busy), 64'(0));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_aL = 1'b1;

    // Single allocate, then read it back.
    applyStimulus("set5", 1'b1, 5, 1'b0, 0, 1'b0, 5, 9);
    checkOutput("set5_vec_const", 64'(busy_vec), 64'h20);
    applyStimulus("rd5", 1'b0, 0, 1'b0, 0, 1'b0, 5, 0);
    checkOutput("rd5_const", 64'(rd0_busy), 64'(1));

    // Clear and set different entries together.
    applyStimulus("set9", 1'b1, 9, 1'b0, 0, 1'b0, 5, 9);
    applyStimulus("clr5set12", 1'b1, 12, 1'b1, 5, 1'b0, 5, 12);
    checkOutput("clr5set12_const", 64'(busy_vec), 64'h1200);

    // Same-index set and clear: set wins. Index 0 is ignored.
    applyStimulus("flush0", 1'b0, 0, 1'b0, 0, 1'b1, 1, 2);
    applyStimulus("set7clr7", 1'b1, 7, 1'b1, 7, 1'b0, 7, 0);
    checkOutput("set7clr7_count", 64'(busy_count), 64'(1));
    applyStimulus("set0", 1'b1, 0, 1'b0, 0, 1'b0, 0, 7);
    applyStimulus("clr0", 1'b0, 0, 1'b1, 0, 1'b0, 0, 7);

    // Fill the table, then flush with a competing set.
    for (int i = 1; i < N; i++) applyStimulus("fill", 1'b1, i, 1'b0, 0, 1'b0, i, 0);
    checkOutput("full_count", 64'(busy_count), 64'(31));
    applyStimulus("resetfull", 1'b1, 4, 1'b0, 0, 1'b0, 4, 31);
    applyStimulus("flushset3", 1'b1, 3, 1'b0, 0, 1'b1, 3, 31);
    checkOutput("flush_idle", 64'(all_idle), 64'(1));

    // Writeback visibility on a read port, including the following cycle.
    applyStimulus("b_set9", 1'b1, 9, 1'b0, 0, 1'b0, 9, 9);
    applyStimulus("b_clr9", 1'b0, 0, 1'b1, 9, 1'b0, 1, 9);
    applyStimulus("b_after", 1'b0, 0, 1'b0, 0, 1'b0, 1, 9);

    // Asynchronous reset between edges drops a pending set.
    applyStimulus("r_set2", 1'b1, 2, 1'b0, 0, 1'b0, 2, 3);
    applyStimulus("r_set3", 1'b1, 3, 1'b0, 0, 1'b0, 2, 3);
    applyStimulus("r_set4", 1'b1, 4, 1'b0, 0, 1'b0, 2, 4);
    @(negedge clk);
    set_valid = 1'b1;
    set_idx   = W'(8);
    clr_valid = 1'b0;
    flush     = 1'b0;
    rd0_idx   = W'(2);
    rd1_idx   = W'(3);
    #2;
    rst_aL = 1'b0;
    #1;
    foreach (modelBusy[i]) modelBusy[i] = 1'b0;
    checkRegs("async_rst");
    checkOutput("async_rst_rd0", 64'(rd0_busy), 64'(0));
    checkOutput("async_rst_rd1", 64'(rd1_busy), 64'(0));
    @(posedge clk);
    #1;
    checkRegs("in_rst");
    @(negedge clk);
    set_valid = 1'b0;
    rst_aL = 1'b1;
    applyStimulus("post_rst", 1'b1, 6, 1'b0, 0, 1'b0, 6, 8);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, N-1)),
                    1'($urandom_range(0, 24) == 0),
                    int'($urandom_range(0, N-1)), int'($urandom_range(0, N-1)));
    end
    idleInputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
